apb_master_bridge: RTL
======================

// Module: apb_master_bridge
// PURPOSE
//  APB initiator: converts a simple valid/ready command port into APB SETUP/ACCESS transfers.
//  Drives the p_* bus toward APB register slaves such as the SSI/SPI register block (CR0..CPSR).
//  Returns read data or error on a one-cycle response strobe.
//  Guards against hung slaves with a p_ready timeout.
// PARAMETERS
//  DATA_WIDTH      32  width of p_wdata/p_rdata/cmd_wdata/rsp_rdata
//  ADDR_WIDTH      32  width of p_addr/cmd_addr
//  TIMEOUT_CYCLES  16  max ACCESS cycles waiting for p_ready; 0 = timeout disabled
// PORTS
//  p_clk      in   1           APB clock, all logic rising-edge
//  p_resetn   in   1           asynchronous active-low reset
//  cmd_valid  in   1           command request
//  cmd_ready  out  1           command accepted when cmd_valid & cmd_ready at clock edge
//  cmd_write  in   1           1 = write, 0 = read
//  cmd_addr   in   ADDR_WIDTH  target address
//  cmd_wdata  in   DATA_WIDTH  write data (ignored for reads)
//  rsp_valid  out  1           one-cycle pulse: transfer finished
//  rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for timeouts
//  rsp_err    out  1           1 with rsp_valid when the transfer timed out
//  p_sel      out  1           APB select
//  p_enable   out  1           APB enable
//  p_write    out  1           APB direction
//  p_addr     out  ADDR_WIDTH  APB address
//  p_wdata    out  DATA_WIDTH  APB write data
//  p_rdata    in   DATA_WIDTH  APB read data, sampled only on completion
//  p_ready    in   1           APB ready, sampled only in ACCESS
// BEHAVIOUR
//  - Reset (async, p_resetn=0):
//    - state=IDLE.
//    - p_sel, p_enable, p_write, p_addr, p_wdata, rsp_valid, rsp_err, rsp_rdata, timeout counter all 0.
//  - Reset mid-transfer: bus drops immediately; no response is issued.
//  - FSM states: IDLE, SETUP, ACCESS.
//    - All p_* and rsp_* outputs are registered.
//    - cmd_ready = (state==IDLE), combinational from state.
//  - IDLE:
//    - p_sel=0, p_enable=0.
//    - On cmd_valid & cmd_ready: latch cmd_write/addr/wdata into p_write/p_addr/p_wdata; go to SETUP.
//  - SETUP (exactly 1 cycle):
//    - p_sel=1, p_enable=0; timeout counter cleared.
//    - Next state is always ACCESS.
//  - ACCESS:
//    - p_sel=1, p_enable=1.
//    - p_addr, p_write and p_wdata are held stable from SETUP through the end of ACCESS.
//  - ACCESS, p_ready=1 at a clock edge:
//    - Next state IDLE; p_sel=p_enable=0.
//    - rsp_valid=1 for one cycle with rsp_err=0.
//    - rsp_rdata = p_rdata for reads, 0 for writes.
//  - ACCESS, p_ready=0 and TIMEOUT_CYCLES!=0:
//    - Counter increments each cycle.
//    - If the counter equals TIMEOUT_CYCLES-1 at the edge: abort to IDLE with p_sel=p_enable=0,
//      rsp_valid=1, rsp_err=1, rsp_rdata=0.
//    - ACCESS therefore lasts at most TIMEOUT_CYCLES cycles.
//  - ACCESS, TIMEOUT_CYCLES=0: wait for p_ready indefinitely.
//  - Latency:
//    - Zero-wait slave: accept edge E0; SETUP from E0 to E1; ACCESS from E1 to E2.
//    - rsp_valid high and cmd_ready=1 from E2.
//    - Minimum transfer period is 3 cycles; each slave wait state adds 1.
//  - Outside ACCESS: p_ready and p_rdata are ignored.
//  - In IDLE, p_addr, p_wdata and p_write keep their last values (no toggling).
//  - rsp_valid has no backpressure; it always pulses exactly one cycle per accepted command.
//  - Simultaneous cmd_valid and completion: a command presented in the completion cycle is not
//    accepted until the following cycle (cmd_ready=0 in ACCESS). No bubbles are inserted beyond that.
// TESTING
//  - Reset: hold p_resetn=0, toggle cmd_valid -> p_sel=p_enable=0, rsp_valid=0, cmd_ready=1, no transfer.
//  - Write, p_ready=1: write 32'h0000_00A5 to 32'h10, p_ready tied 1
//    -> p_sel for 2 cycles, p_enable in cycle 2, p_addr=32'h10 stable;
//    -> rsp_valid=1 after 3rd edge with rsp_err=0, rsp_rdata=0.
//  - Read, 2 wait states: read from 32'h0C, slave drives p_rdata=32'h1F, p_ready low for 2 ACCESS cycles
//    -> ACCESS lasts 3 cycles; rsp_rdata=32'h1F, rsp_err=0.
//  - Timeout: TIMEOUT_CYCLES=16, p_ready stuck 0 -> exactly 16 ACCESS cycles;
//    -> then p_sel=0, rsp_valid=1, rsp_err=1, rsp_rdata=0; next command accepted afterwards.
//  - Back-to-back: cmd_valid held high with writes to 0x0 then 0x4 -> second p_sel rises 1 cycle after first completes;
//    -> p_addr changes only in IDLE/SETUP; 2 rsp_valid pulses.
//  - Reset mid-ACCESS: assert p_resetn=0 in ACCESS -> p_sel/p_enable drop asynchronously;
//    -> no rsp_valid; after release cmd_ready=1.

Source files
------------

// File: rtl/apb_master_bridge.sv
// APB initiator: turns a valid/ready command into one SETUP/ACCESS transfer and
// reports completion (or a p_ready timeout) on a single-cycle response strobe.
module apb_master_bridge #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  p_clk,
  input  logic                  p_resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  p_sel,
  output logic                  p_enable,
  output logic                  p_write,
  output logic [ADDR_WIDTH-1:0] p_addr,
  output logic [DATA_WIDTH-1:0] p_wdata,
  input  logic [DATA_WIDTH-1:0] p_rdata,
  input  logic                  p_ready
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam int CNT_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TMO_LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] TMO_LAST = TMO_LAST_INT[CNT_W-1:0];

  state_t                  state_q, state_d;
  logic                    p_sel_q, p_sel_d;
  logic                    p_enable_q, p_enable_d;
  logic                    p_write_q, p_write_d;
  logic [ADDR_WIDTH-1:0]   p_addr_q, p_addr_d;
  logic [DATA_WIDTH-1:0]   p_wdata_q, p_wdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [CNT_W-1:0]        tmo_cnt_q, tmo_cnt_d;
  logic                    tmo_hit;

  // The counter holds the number of ACCESS cycles already spent without p_ready,
  // so matching TIMEOUT_CYCLES-1 means this is the last permitted cycle.
  generate
    if (TMO_EN) begin : g_tmo
      assign tmo_hit = (tmo_cnt_q == TMO_LAST);
    end else begin : g_no_tmo
      assign tmo_hit = 1'b0;
    end
  endgenerate

  assign cmd_ready = (state_q == ST_IDLE);

  always_comb begin
    state_d     = state_q;
    p_sel_d     = p_sel_q;
    p_enable_d  = p_enable_q;
    p_write_d   = p_write_q;
    p_addr_d    = p_addr_q;
    p_wdata_d   = p_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    tmo_cnt_d   = tmo_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        p_sel_d    = 1'b0;
        p_enable_d = 1'b0;
        if (cmd_valid) begin
          state_d   = ST_SETUP;
          p_sel_d   = 1'b1;
          p_write_d = cmd_write;
          p_addr_d  = cmd_addr;
          p_wdata_d = cmd_wdata;
        end
      end

      ST_SETUP: begin
        state_d    = ST_ACCESS;
        p_sel_d    = 1'b1;
        p_enable_d = 1'b1;
        tmo_cnt_d  = '0;
      end

      ST_ACCESS: begin
        if (p_ready) begin
          state_d     = ST_IDLE;
          p_sel_d     = 1'b0;
          p_enable_d  = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = p_write_q ? '0 : p_rdata;
        end else if (tmo_hit) begin
          state_d     = ST_IDLE;
          p_sel_d     = 1'b0;
          p_enable_d  = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else if (TMO_EN) begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d    = ST_IDLE;
        p_sel_d    = 1'b0;
        p_enable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      state_q     <= ST_IDLE;
      p_sel_q     <= 1'b0;
      p_enable_q  <= 1'b0;
      p_write_q   <= 1'b0;
      p_addr_q    <= '0;
      p_wdata_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      p_sel_q     <= p_sel_d;
      p_enable_q  <= p_enable_d;
      p_write_q   <= p_write_d;
      p_addr_q    <= p_addr_d;
      p_wdata_q   <= p_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign p_sel     = p_sel_q;
  assign p_enable  = p_enable_q;
  assign p_write   = p_write_q;
  assign p_addr    = p_addr_q;
  assign p_wdata   = p_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
